hex_scan_controller: RTL and testbench

Sequences one shared hex_decoder instance across DIGITS seven-segment displays. On a load request it captures a packed nibble vector and steps a digit index through the decoder. It holds each digit for STEP_CYCLES cycles, then latches the decoder output into that digit's segment register. It sits between the value source (counter or switch logic) and the HEX0..HEX5 pins, so the design needs one decoder instead of DIGITS copies.

---
 rtl/hex_scan_controller.sv | 150 +++++++++++++++
 tb/tb_hex_scan_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hex_scan_controller.sv
// hex_scan_controller: shares one hex_decoder across DIGITS seven-segment displays.
// Optional macro HEX_SCAN_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.

module hex_decoder (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_c
);
  // Active-low segments, bit 0 = segment a
  always_comb begin
    o_seg_c = 7'h7F;
    case (i_nibble)
      4'h0: o_seg_c = 7'h40;
      4'h1: o_seg_c = 7'h79;
      4'h2: o_seg_c = 7'h24;
      4'h3: o_seg_c = 7'h30;
      4'h4: o_seg_c = 7'h19;
      4'h5: o_seg_c = 7'h12;
      4'h6: o_seg_c = 7'h02;
      4'h7: o_seg_c = 7'h78;
      4'h8: o_seg_c = 7'h00;
      4'h9: o_seg_c = 7'h10;
      4'hA: o_seg_c = 7'h08;
      4'hB: o_seg_c = 7'h03;
      4'hC: o_seg_c = 7'h46;
      4'hD: o_seg_c = 7'h21;
      4'hE: o_seg_c = 7'h06;
      4'hF: o_seg_c = 7'h0E;
      default: o_seg_c = 7'h7F;
    endcase
  end
endmodule

module hex_scan_controller #(
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_value,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [7*DIGITS-1:0]   o_seg
);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DW_W-1:0]  LAST_DW  = DW_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_index;
  logic [DW_W-1:0]     r_dwell;
  logic [4*DIGITS-1:0] r_value;
  logic                r_busy;
  logic                r_done;
  logic [7*DIGITS-1:0] r_seg;

  logic [3:0] w_nibble;
  logic [6:0] w_dec;
  logic [6:0] w_digit;

  // Select the captured nibble for the digit currently being scanned
  always_comb begin
    w_nibble = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_index == IDX_W'(k)) w_nibble = r_value[4*k +: 4];
    end
  end

  hex_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg_c  (w_dec)
  );

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] r_msd;
  logic [IDX_W-1:0] w_msd;

  // Highest nonzero nibble of the incoming value; 0 when the value is all zero
  always_comb begin
    w_msd = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (i_value[4*k +: 4] != 4'h0) w_msd = IDX_W'(k);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_msd <= '0;
    end else if (r_state == S_IDLE && i_load) begin
      r_msd <= w_msd;
    end
  end

  assign w_digit = (r_index > r_msd) ? 7'h7F : w_dec;
`else
  assign w_digit = w_dec;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_seg   <= {DIGITS{7'h7F}};
      r_index <= '0;
      r_dwell <= '0;
      r_value <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_value <= i_value;
            r_index <= '0;
            r_dwell <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_dwell == LAST_DW) begin
            r_dwell <= '0;
            for (int k = 0; k < DIGITS; k++) begin
              if (r_index == IDX_W'(k)) r_seg[7*k +: 7] <= w_digit;
            end
            if (r_index == LAST_IDX) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_index <= r_index + IDX_W'(1);
            end
          end else begin
            r_dwell <= r_dwell + DW_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_seg  = r_seg;

endmodule

// File: tb/tb_hex_scan_controller.sv
// Randomized bench for hex_scan_controller: two instances (dwell 1 and 3) checked every cycle
// against a time-since-capture reference model.
module tb_hex_scan_controller;
  localparam int DIGITS = 6;
  localparam int SW     = 7 * DIGITS;
  localparam int VW     = 4 * DIGITS;
  localparam int STEP_OF [2] = '{1, 3};
  localparam logic [6:0] LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ld0, ld1;
  logic [VW-1:0] v0, v1;
  logic          busy0, done0, busy1, done1;
  logic [SW-1:0] seg0, seg1;

  hex_scan_controller #(.DIGITS(DIGITS), .STEP_CYCLES(1)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_load(ld0), .i_value(v0),
    .o_busy(busy0), .o_done(done0), .o_seg(seg0));

  hex_scan_controller #(.DIGITS(DIGITS), .STEP_CYCLES(3)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_load(ld1), .i_value(v1),
    .o_busy(busy1), .o_done(done1), .o_seg(seg1));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state: whether a scan is running, how many cycles since capture, old and new display
  bit            m_act  [2];
  int            m_c    [2];
  logic [SW-1:0] m_disp [2];
  logic [SW-1:0] m_new  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  function automatic logic [SW-1:0] model_seg(input logic [VW-1:0] v);
    logic [SW-1:0] s;
    logic [3:0]    nib;
    int            top;
    top = 0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = v[4*k +: 4];
      if (nib != 4'h0) top = k;
    end
    for (int k = 0; k < DIGITS; k++) begin
      nib = v[4*k +: 4];
      s[7*k +: 7] = LUT[nib];
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
      if (k > top) s[7*k +: 7] = 7'h7F;
`endif
    end
    return s;
  endfunction

  task automatic model_step(input int u, input logic r, input logic l, input logic [VW-1:0] v);
    if (r) begin
      m_act[u]  = 1'b0;
      m_c[u]    = 0;
      m_disp[u] = {DIGITS{7'h7F}};
    end else if (m_act[u]) begin
      m_c[u]++;
      if (m_c[u] > DIGITS * STEP_OF[u] + 1) begin
        m_act[u]  = 1'b0;
        m_disp[u] = m_new[u];
      end
    end else if (l) begin
      m_act[u] = 1'b1;
      m_c[u]   = 1;
      m_new[u] = model_seg(v);
    end
  endtask

  task automatic compare(input int u, input logic b, input logic d, input logic [SW-1:0] s);
    logic          eb, ed;
    logic [SW-1:0] es;
    if (m_act[u]) begin
      eb = (m_c[u] <= DIGITS * STEP_OF[u]);
      ed = (m_c[u] == DIGITS * STEP_OF[u] + 1);
      for (int k = 0; k < DIGITS; k++)
        es[7*k +: 7] = (m_c[u] >= (k + 1) * STEP_OF[u] + 1) ? m_new[u][7*k +: 7] : m_disp[u][7*k +: 7];
    end else begin
      eb = 1'b0;
      ed = 1'b0;
      es = m_disp[u];
    end
    check($sformatf("busy%0d", u), 64'(b), 64'(eb));
    check($sformatf("done%0d", u), 64'(d), 64'(ed));
    check($sformatf("seg%0d", u), 64'(s), 64'(es));
  endtask

  // Drive one cycle of inputs at the falling edge, then check after the next rising edge
  task automatic cycle(input logic r, input logic l0, input logic [VW-1:0] a0,
                       input logic l1, input logic [VW-1:0] a1);
    rst = r; ld0 = l0; v0 = a0; ld1 = l1; v1 = a1;
    @(negedge clk);
    cyc++;
    model_step(0, r, l0, a0);
    model_step(1, r, l1, a1);
    compare(0, busy0, done0, seg0);
    compare(1, busy1, done1, seg1);
  endtask

  function automatic logic [VW-1:0] rnd_val();
    return VW'({$urandom, $urandom});
  endfunction

  initial begin
    logic [SW-1:0] exp2, exp6;

    // Reset then idle
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, rnd_val(), 1'b0, rnd_val());
    check("reset_seg", 64'(seg0), 64'({DIGITS{7'h7F}}));

    // Single load of 000810, value scrambled after capture
    cycle(1'b0, 1'b1, 24'h000810, 1'b0, '0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, rnd_val(), 1'b0, '0);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    exp2 = {7'h7F, 7'h7F, 7'h7F, 7'h00, 7'h79, 7'h40};
`else
    exp2 = {7'h40, 7'h40, 7'h40, 7'h00, 7'h79, 7'h40};
`endif
    check("t2_seg", 64'(seg0), 64'(exp2));

    // Load held high with a changing value
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, rnd_val(), 1'b1, rnd_val());
    for (int i = 0; i < 22; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);

    // Three-cycle dwell scan of 111111
    cycle(1'b0, 1'b0, '0, 1'b1, 24'h111111);
    for (int i = 0; i < 22; i++) cycle(1'b0, 1'b0, '0, 1'b0, rnd_val());

    // Reset in the third cycle of an 888888 scan, then a normal scan
    cycle(1'b0, 1'b1, 24'h888888, 1'b1, 24'h888888);
    cycle(1'b0, 1'b0, '0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    check("abort_seg", 64'(seg0), 64'({DIGITS{7'h7F}}));
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);
    cycle(1'b0, 1'b1, 24'h5A3C07, 1'b1, 24'h5A3C07);
    for (int i = 0; i < 22; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);

    // All-zero value
    cycle(1'b0, 1'b1, 24'h000000, 1'b0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    exp6 = {{(DIGITS-1){7'h7F}}, 7'h40};
`else
    exp6 = {DIGITS{7'h40}};
`endif
    check("t6_seg", 64'(seg0), 64'(exp6));

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0), rnd_val(),
            ($urandom_range(0, 5) == 0), rnd_val());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
